poly_basemul: RTL and testbench



---
 rtl/kyber_pkg.sv | 47 ++++
 rtl/poly_basemul_if.sv | 27 ++
 rtl/fqmul.sv | 28 ++
 rtl/poly_basemul.sv | 167 ++++++++++++++++
 tb/tb_poly_basemul.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/kyber_pkg.sv
// Shared Kyber arithmetic constants, twiddle table and the basemul FSM state type.
package kyber_pkg;

  localparam int KYBER_Q    = 3329;
  localparam int KYBER_QINV = -3327;
  localparam int MONT_R     = 2285;

  localparam int unsigned KYBER_N   = 256;
  localparam int unsigned NUM_PAIRS = 128;

  typedef logic signed [15:0] coef_t;

  // Montgomery-domain twiddles in bit-reversed order, as used by ntt/intt/basemul
  localparam coef_t ZETAS [128] = '{
    -16'sd1044,  -16'sd758,  -16'sd359, -16'sd1517,  16'sd1493,  16'sd1422,   16'sd287,   16'sd202,
     -16'sd171,   16'sd622,  16'sd1577,   16'sd182,   16'sd962, -16'sd1202, -16'sd1474,  16'sd1468,
      16'sd573, -16'sd1325,   16'sd264,   16'sd383,  -16'sd829,  16'sd1458, -16'sd1602,  -16'sd130,
     -16'sd681,  16'sd1017,   16'sd732,   16'sd608, -16'sd1542,   16'sd411,  -16'sd205, -16'sd1571,
     16'sd1223,   16'sd652,  -16'sd552,  16'sd1015, -16'sd1293,  16'sd1491,  -16'sd282, -16'sd1544,
      16'sd516,    -16'sd8,  -16'sd320,  -16'sd666, -16'sd1618, -16'sd1162,   16'sd126,  16'sd1469,
     -16'sd853,   -16'sd90,  -16'sd271,   16'sd830,   16'sd107, -16'sd1421,  -16'sd247,  -16'sd951,
     -16'sd398,   16'sd961, -16'sd1508,  -16'sd725,   16'sd448, -16'sd1065,   16'sd677, -16'sd1275,
    -16'sd1103,   16'sd430,   16'sd555,   16'sd843, -16'sd1251,   16'sd871,  16'sd1550,   16'sd105,
      16'sd422,   16'sd587,   16'sd177,  -16'sd235,  -16'sd291,  -16'sd460,  16'sd1574,  16'sd1653,
     -16'sd246,   16'sd778,  16'sd1159,  -16'sd147,  -16'sd777,  16'sd1483,  -16'sd602,  16'sd1119,
    -16'sd1590,   16'sd644,  -16'sd872,   16'sd349,   16'sd418,   16'sd329,  -16'sd156,   -16'sd75,
      16'sd817,  16'sd1097,   16'sd603,   16'sd610,  16'sd1322, -16'sd1285, -16'sd1465,   16'sd384,
    -16'sd1215,  -16'sd136,  16'sd1218, -16'sd1335,  -16'sd874,   16'sd220, -16'sd1187, -16'sd1659,
    -16'sd1185, -16'sd1530, -16'sd1278,   16'sd794, -16'sd1510,  -16'sd854,  -16'sd870,   16'sd478,
     -16'sd108,  -16'sd308,   16'sd996,   16'sd991,   16'sd958, -16'sd1460,  16'sd1522,  16'sd1628
  };

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } basemul_state_t;

  // Pair p uses the upper half of the table; odd pairs take the negated twiddle
  function automatic coef_t basemul_zeta(logic [6:0] p);
    coef_t z;
    z = ZETAS[{1'b1, p[6:1]}];
    return p[0] ? -z : z;
  endfunction

endpackage

// File: rtl/poly_basemul_if.sv
// Operand/result bundle between a basemul requester and the multiplier.
interface poly_basemul_if;
  import kyber_pkg::*;

  logic  enable;
  coef_t a   [KYBER_N];
  coef_t b   [KYBER_N];
  coef_t out [KYBER_N];
  logic  valid;

  modport master (
    output enable,
    output a,
    output b,
    input  out,
    input  valid
  );

  modport slave (
    input  enable,
    input  a,
    input  b,
    output out,
    output valid
  );

endinterface

// File: rtl/fqmul.sv
// Combinational Montgomery multiply: z = x*y*2^-16 mod q, result in (-q, q).
module fqmul
  import kyber_pkg::*;
(
  input  coef_t x_i,
  input  coef_t y_i,
  output coef_t z_o
);

  localparam logic [15:0]        QInv16 = 16'(KYBER_QINV);
  localparam logic signed [31:0] Q32    = 32'(KYBER_Q);

  logic signed [31:0] prod;
  logic        [15:0] u;
  logic signed [31:0] u_ext;
  logic signed [31:0] diff;

  // Montgomery reduction of the signed 32-bit product; only the low half feeds u
  always_comb begin
    prod  = $signed({{16{x_i[15]}}, x_i}) * $signed({{16{y_i[15]}}, y_i});
    u     = prod[15:0] * QInv16;
    u_ext = $signed({{16{u[15]}}, u});
    diff  = prod - u_ext * Q32;
    // diff is an exact multiple of 2^16, so the arithmetic shift loses nothing
    z_o   = 16'(diff >>> 16);
  end

endmodule

// File: rtl/poly_basemul.sv
// Pointwise NTT-domain product of two Kyber polynomials: one coefficient pair per clock
// through a three-stage Montgomery pipeline into a registered 256-entry result.
module poly_basemul
  import kyber_pkg::*;
(
  input logic           clk,
  input logic           reset,
  poly_basemul_if.slave bus_io
);

  // Control
  basemul_state_t state_q, state_d;
  logic [6:0]     idx_q, idx_d;
  logic           drain_q, drain_d;
  logic           valid_q, valid_d;

  // Issue-side operands
  logic  issue;
  coef_t a0, a1, b0, b1;
  coef_t zeta;

  // Stage 1
  coef_t      m11, m00, m01, m10;
  logic       s1_valid_q;
  logic [6:0] s1_p_q;
  coef_t      s1_zeta_q;
  coef_t      m11_q, m00_q, m01_q, m10_q;

  // Stage 2
  coef_t      mz;
  logic       s2_valid_q;
  logic [6:0] s2_p_q;
  coef_t      mz_q, s2_m00_q, s2_sum_q;

  // Stage 3 / result
  coef_t out_q [KYBER_N];

  // FSM state, pair index, drain counter and result-valid flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      drain_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drain_q <= drain_d;
      valid_q <= valid_d;
    end
  end

  // Next-state logic: IDLE -> RUN (128 issues) -> DRAIN (2 cycles) -> DONE -> IDLE
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    drain_d = drain_q;
    valid_d = valid_q;
    case (state_q)
      StIdle: begin
        if (bus_io.enable) begin
          state_d = StRun;
          idx_d   = '0;
        end
      end
      StRun: begin
        // enable is deliberately ignored once a run has started
        idx_d = idx_q + 7'd1;
        if (idx_q == 7'(NUM_PAIRS - 1)) begin
          state_d = StDrain;
          drain_d = 1'b0;
        end
      end
      StDrain: begin
        drain_d = 1'b1;
        if (drain_q) begin
          // Last pair retires on this same edge, so valid rises with the final write
          state_d = StDone;
          valid_d = 1'b1;
        end
      end
      StDone: begin
        // Holding enable keeps the result frozen; a new run needs a pass through IDLE
        if (!bus_io.enable) begin
          state_d = StIdle;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output decode: pick the operand pair and twiddle for the index being issued
  always_comb begin
    issue = (state_q == StRun);
    a0    = bus_io.a[{idx_q, 1'b0}];
    a1    = bus_io.a[{idx_q, 1'b1}];
    b0    = bus_io.b[{idx_q, 1'b0}];
    b1    = bus_io.b[{idx_q, 1'b1}];
    zeta  = basemul_zeta(idx_q);
  end

  fqmul u_fq_m11 (.x_i(a1), .y_i(b1), .z_o(m11));
  fqmul u_fq_m00 (.x_i(a0), .y_i(b0), .z_o(m00));
  fqmul u_fq_m01 (.x_i(a0), .y_i(b1), .z_o(m01));
  fqmul u_fq_m10 (.x_i(a1), .y_i(b0), .z_o(m10));

  // Stage 1: four cross products plus the pair's twiddle and index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_p_q     <= '0;
      s1_zeta_q  <= '0;
      m11_q      <= '0;
      m00_q      <= '0;
      m01_q      <= '0;
      m10_q      <= '0;
    end else begin
      s1_valid_q <= issue;
      if (issue) begin
        s1_p_q    <= idx_q;
        s1_zeta_q <= zeta;
        m11_q     <= m11;
        m00_q     <= m00;
        m01_q     <= m01;
        m10_q     <= m10;
      end
    end
  end

  fqmul u_fq_mz (.x_i(m11_q), .y_i(s1_zeta_q), .z_o(mz));

  // Stage 2: twiddle the high product and fold the odd-coefficient sum (16-bit wrap)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      s2_p_q     <= '0;
      mz_q       <= '0;
      s2_m00_q   <= '0;
      s2_sum_q   <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_p_q   <= s1_p_q;
        mz_q     <= mz;
        s2_m00_q <= m00_q;
        s2_sum_q <= m01_q + m10_q;
      end
    end
  end

  // Stage 3: each retiring pair overwrites its two result slots; others keep old data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= '{default: '0};
    end else if (s2_valid_q) begin
      out_q[{s2_p_q, 1'b0}] <= mz_q + s2_m00_q;
      out_q[{s2_p_q, 1'b1}] <= s2_sum_q;
    end
  end

  assign bus_io.out   = out_q;
  assign bus_io.valid = valid_q;

endmodule

// File: tb/tb_poly_basemul.sv
// Scoreboard bench for poly_basemul: stimulus pushes expected results, a monitor checks
// every rising valid for latency and full 256-coefficient contents.
module tb_poly_basemul;

  typedef logic [255:0][15:0] pvec_t;
  typedef struct packed {
    logic [31:0] start;
    pvec_t       coefs;
  } exp_t;

  // Upper half of the Kyber twiddle table (indices 64..127)
  localparam int ZUP [64] = '{
    -1103,   430,   555,   843, -1251,   871,  1550,   105,
      422,   587,   177,  -235,  -291,  -460,  1574,  1653,
     -246,   778,  1159,  -147,  -777,  1483,  -602,  1119,
    -1590,   644,  -872,   349,   418,   329,  -156,   -75,
      817,  1097,   603,   610,  1322, -1285, -1465,   384,
    -1215,  -136,  1218, -1335,  -874,   220, -1187, -1659,
    -1185, -1530, -1278,   794, -1510,  -854,  -870,   478,
     -108,  -308,   996,   991,   958, -1460,  1522,  1628
  };

  logic        clk = 1'b0;
  logic        reset;
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        sb_q [$];
  logic        mon_prev = 1'b0;
  exp_t        mon_e;

  poly_basemul_if bus ();

  poly_basemul dut (
    .clk   (clk),
    .reset (reset),
    .bus_io(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // C-reference arithmetic
  function automatic logic signed [15:0] fq(input logic signed [15:0] x,
                                            input logic signed [15:0] y);
    int t;
    logic signed [15:0] tl;
    logic signed [15:0] u;
    t  = int'(x) * int'(y);
    tl = 16'(t);
    u  = 16'(int'(tl) * -3327);
    return 16'((t - int'(u) * 3329) >>> 16);
  endfunction

  function automatic pvec_t model(input pvec_t av, input pvec_t bv);
    pvec_t r;
    for (int p = 0; p < 128; p++) begin
      logic signed [15:0] a0, a1, b0, b1, z;
      a0 = av[2*p];
      a1 = av[2*p+1];
      b0 = bv[2*p];
      b1 = bv[2*p+1];
      z  = 16'(ZUP[p/2]);
      if (p % 2 == 1) z = -z;
      r[2*p]   = fq(fq(a1, b1), z) + fq(a0, b0);
      r[2*p+1] = fq(a0, b1) + fq(a1, b0);
    end
    return r;
  endfunction

  task automatic check_bit(input string name, input logic got, input logic want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%b want=%b (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic check_out(input string name, input pvec_t ev);
    int first;
    first = -1;
    for (int i = 0; i < 256; i++) begin
      if (first < 0 && bus.out[i] !== ev[i]) first = i;
    end
    n_cmp++;
    if (first >= 0) begin
      n_bad++;
      $display("FAIL %s out[%0d] got=%0d want=%0d (cycle %0d)", name, first,
               bus.out[first], $signed(ev[first]), cyc);
    end
  endtask

  task automatic load(input pvec_t av, input pvec_t bv);
    for (int i = 0; i < 256; i++) begin
      bus.a[i] = av[i];
      bus.b[i] = bv[i];
    end
  endtask

  // Start a run on the next edge (E0); optionally drop enable at E<drop_at>, optionally
  // hold enable in DONE for 20 cycles before releasing it.
  task automatic run_vec(input string name, input pvec_t av, input pvec_t bv,
                         input pvec_t ev, input int drop_at, input bit hold);
    exp_t e;
    bit   seen;
    load(av, bv);
    bus.enable = 1'b1;
    @(posedge clk);
    #1;
    e.start = cyc;
    e.coefs = ev;
    sb_q.push_back(e);
    seen = 1'b0;
    for (int k = 1; k <= 200 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (k == drop_at) bus.enable = 1'b0;
      if (bus.valid === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL %s_valid_timeout got=0 want=1 within 200 cycles", name);
    end
    if (hold) begin
      for (int k = 0; k < 20; k++) begin
        @(posedge clk);
        #1;
        check_bit({name, "_hold_valid"}, bus.valid, 1'b1);
        check_out({name, "_hold_out"}, ev);
      end
    end
    bus.enable = 1'b0;
    @(posedge clk);
    #1;
    check_bit({name, "_valid_drop"}, bus.valid, 1'b0);
    if (hold) check_out({name, "_idle_keep"}, ev);
  endtask

  // Monitor: every rising valid retires one scoreboard entry
  initial begin
    forever begin
      @(negedge clk);
      if (bus.valid === 1'b1 && mon_prev !== 1'b1) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_valid got=1 want=0 (cycle %0d)", cyc);
        end else begin
          mon_e = sb_q.pop_front();
          n_cmp++;
          if (int'(cyc - mon_e.start) != 130) begin
            n_bad++;
            $display("FAIL latency got=%0d want=130", int'(cyc - mon_e.start));
          end
          check_out("sb_result", mon_e.coefs);
        end
      end
      mon_prev = bus.valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pvec_t va, vb, ve, zero;
    zero = '0;
    bus.enable = 1'b0;
    load(zero, zero);
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    check_bit("rst_valid", bus.valid, 1'b0);
    check_out("rst_out", zero);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // All-zero operands, started on the first edge after reset release
    run_vec("zeros", zero, zero, zero, 0, 1'b0);

    // Even pair: R*R -> zeta of pair 0
    va = '0; vb = '0; ve = '0;
    va[1] = 16'sd2285; vb[1] = 16'sd2285;
    ve[0] = -16'sd1103;
    run_vec("even_zeta", va, vb, ve, 0, 1'b0);

    // Odd pair: negated twiddle
    va = '0; vb = '0; ve = '0;
    va[3] = 16'sd2285; vb[3] = 16'sd2285;
    ve[2] = 16'sd1103;
    run_vec("odd_zeta", va, vb, ve, 0, 1'b0);

    // Mixed directed vector, enable dropped mid-run
    va = '0; vb = '0; ve = '0;
    va[0] = 16'sd2285; va[1] = 16'sd2285; vb[0] = 16'sd2285; vb[1] = 16'sd2285;
    ve[0] = -16'sd2147; ve[1] = -16'sd2088;
    va[4] = 16'sd1;  vb[4] = 16'sd1;  ve[4] = 16'sd169;
    va[6] = -16'sd1; vb[6] = 16'sd1;  ve[6] = -16'sd169;
    va[9] = 16'sd2285; vb[8] = 16'sd2285; ve[9] = -16'sd1044;
    va[255] = 16'sd2285; vb[255] = 16'sd2285; ve[254] = -16'sd1628;
    run_vec("mixed_drop", va, vb, ve, 50, 1'b0);

    // Pseudo-random operands against the reference model, held in DONE
    for (int i = 0; i < 256; i++) begin
      va[i] = 16'(int'($urandom_range(6656, 0)) - 3328);
      vb[i] = 16'(int'($urandom_range(6656, 0)) - 3328);
    end
    ve = model(va, vb);
    run_vec("rand_hold", va, vb, ve, 0, 1'b1);

    // Asynchronous reset mid-run
    va = '0; vb = '0;
    va[1] = 16'sd2285; vb[1] = 16'sd2285;
    load(va, vb);
    bus.enable = 1'b1;
    repeat (61) @(posedge clk);
    #1;
    reset = 1'b1;
    bus.enable = 1'b0;
    #1;
    check_bit("midrun_rst_valid", bus.valid, 1'b0);
    check_out("midrun_rst_out", zero);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Fresh run straight after reset
    for (int i = 0; i < 256; i++) begin
      va[i] = 16'(int'($urandom_range(6656, 0)) - 3328);
      vb[i] = 16'(int'($urandom_range(6656, 0)) - 3328);
    end
    ve = model(va, vb);
    run_vec("post_rst", va, vb, ve, 0, 1'b0);

    repeat (5) @(posedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain got=%0d pending want=0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
